// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths and the writeback entry type
package rv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREGS = 32;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/load/issue inputs, load ready, busy scoreboard and register-file write port
interface regfile_writeback_if;
  import rv_pkg::*;
  logic alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic ld_valid;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0] ld_data;
  logic ld_ready;
  logic issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic [NREGS-1:0] busy;
  logic rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0] rf_wdata;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
    input ld_ready, busy, rf_we, rf_rd, rf_wdata
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
    output ld_ready, busy, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO (clk, rst, push/din, pop/dout, full, empty, count)
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and FIFO-buffered load results onto the single register-file write port and keeps the load busy scoreboard
module regfile_writeback
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  regfile_writeback_if.slave wb
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  wb_entry_t head, ld_in, sel;
  logic full, empty, pop, sel_v, from_fifo;
  logic [CW-1:0] count;
  logic [NREGS-1:0] clr, set;
  assign ld_in = '{rd: wb.ld_rd, data: wb.ld_data};
  assign wb.ld_ready = count < CW'(FIFO_DEPTH);
  assign pop = !wb.alu_valid && !empty;
  assign sel_v = wb.alu_valid || !empty;
  assign sel = wb.alu_valid ? '{rd: wb.alu_rd, data: wb.alu_data} : head;
  assign clr = (wb.rf_we && from_fifo) ? NREGS'(1) << wb.rf_rd : '0;
  assign set = (wb.issue_valid && wb.issue_rd != '0) ? NREGS'(1) << wb.issue_rd : '0;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(wb_entry_t))) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(wb.ld_valid && !full),
    .pop(pop),
    .din(ld_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      wb.rf_we <= 1'b0;
      wb.rf_rd <= '0;
      wb.rf_wdata <= '0;
      wb.busy <= '0;
      from_fifo <= 1'b0;
    end else begin
      wb.rf_we <= sel_v && sel.rd != '0;
      if (sel_v) begin
        wb.rf_rd <= sel.rd;
        wb.rf_wdata <= sel.data;
      end
      from_fifo <= pop;
      wb.busy <= (wb.busy & ~clr) | set;
    end
endmodule
